// File: rtl/instr_fetch_unit.sv
// Fetch stage: addresses the combinational instruction memory and queues {pc, instr} for decode.
// Latency: an instruction at address A appears on out_* one edge after imem_addr==A; the first out_valid rises on the second edge after reset.
// Backpressure: fetch stalls with imem_addr held while the buffer is full and decode is not popping; a redirect flushes the buffer.
// Optional feature macro: BRANCH_PREDECODE_EN (follows j-type jumps at fetch time).
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_count
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_ent_t;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2
    } state_t;

    localparam int                PTR_W    = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam logic [2:0]        DEPTH_C  = 3'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    fetch_ent_t       fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [2:0]       level;
    logic [2:0]       level_next;
    state_t           state;
    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    logic [31:0]      next_fetch_pc;
    logic             pop;
    logic             push;
    logic             can_capture;
    logic             misalign_q;
    logic [CNT_W-1:0] count_q;

    // Circular pointer increment that also handles a non power-of-two depth.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake and capture decisions; a redirect suppresses the capture of the current word.
    always_comb begin
        pop         = (level != 3'd0) && out_ready;
        can_capture = (state == RUN) || ((state == FULL) && pop);
        push        = can_capture && !redirect_valid;
    end

    // Sequential next fetch address, optionally following a j-type jump found in the fetched word.
    always_comb begin
        pc_plus4      = pc + 32'd4;
        next_fetch_pc = pc_plus4;
`ifdef BRANCH_PREDECODE_EN
        if (imem_data[31:26] == 6'b000010) begin
            next_fetch_pc = {pc_plus4[31:28], imem_data[25:0], 2'b00};
        end
`else
        next_fetch_pc = pc_plus4;
`endif
    end

    // Occupancy after this edge; a redirect empties the buffer whatever else happens.
    always_comb begin
        level_next = level;
        if (redirect_valid) begin
            level_next = 3'd0;
        end else begin
            case ({push, pop})
                2'b10:   level_next = level + 3'd1;
                2'b01:   level_next = level - 3'd1;
                default: level_next = level;
            endcase
        end
    end

    // Fetch controller: BOOT spends one edge out of reset, FULL tracks a full buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN, FULL: begin
                    if (redirect_valid) begin
                        state <= RUN;
                    end else if (level_next == DEPTH_C) begin
                        state <= FULL;
                    end else begin
                        state <= RUN;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    // Program counter: redirect wins, otherwise advance only when a word is captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[31:2], 2'b00};
        end else if (push) begin
            pc <= next_fetch_pc;
        end
    end

    // Buffer pointers and occupancy; a flush rewinds both pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= 3'd0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= 3'd0;
        end else begin
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            level <= level_next;
        end
    end

    // Buffer storage; contents of empty slots never reach the outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr] <= '{pc: pc, instr: imem_data};
        end
    end

    // Sticky flag for redirect targets that are not word aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end

    // Saturating count of entries accepted by decode, including a pop that coincides with a redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (pop && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // Head of buffer drives decode; outputs read zero while empty.
    always_comb begin
        out_valid = (level != 3'd0);
        out_pc    = 32'h0;
        out_instr = 32'h0;
        if (out_valid) begin
            out_pc    = fifo_q[rd_ptr].pc;
            out_instr = fifo_q[rd_ptr].instr;
        end
    end

    assign imem_addr    = pc;
    assign misalign_err = misalign_q;
    assign fetch_count  = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by randomized traffic.
// Every cycle the DUT outputs are compared with a queue-based reference model.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam int          DEPTH  = 2;
    localparam int          CW     = 4;

    logic          clk;
    logic          rst;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          misalign_err;
    logic [CW-1:0] fetch_count;

    logic [31:0] mem [64];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc;
    bit          m_boot;
    bit          m_mis;
    int          m_cnt;
    int          n_checks;
    int          n_errors;

    instr_fetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misalign_err   (misalign_err),
        .fetch_count    (fetch_count)
    );

    assign imem_data = mem[imem_addr[7:2]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
    task automatic step(input bit r, input bit rdy, input bit rv, input logic [31:0] rpc);
        ent_t        e;
        logic [31:0] nxt;
        bit          pop;
        int          sz;
        @(negedge clk);
        rst            = r;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        check("imem_addr", imem_addr, m_pc);
        check("out_valid", {31'b0, out_valid}, (q.size() > 0) ? 32'd1 : 32'd0);
        check("out_pc", out_pc, (q.size() > 0) ? q[0].pc : 32'h0);
        check("out_instr", out_instr, (q.size() > 0) ? q[0].ins : 32'h0);
        check("misalign_err", {31'b0, misalign_err}, m_mis ? 32'd1 : 32'd0);
        check("fetch_count", {{(32-CW){1'b0}}, fetch_count}, 32'(m_cnt));
        if (r) begin
            q.delete();
            m_pc   = RST_PC;
            m_boot = 0;
            m_mis  = 0;
            m_cnt  = 0;
        end else begin
            sz  = q.size();
            pop = (sz > 0) && rdy;
            if (pop) begin
                void'(q.pop_front());
                if (m_cnt < (1 << CW) - 1) m_cnt++;
            end
            if (rv) begin
                q.delete();
                m_pc = {rpc[31:2], 2'b00};
                if (rpc[1:0] != 2'b00) m_mis = 1;
            end else if (m_boot && (sz < DEPTH || pop)) begin
                e.pc  = m_pc;
                e.ins = mem[m_pc[7:2]];
                q.push_back(e);
                nxt = m_pc + 32'd4;
`ifdef BRANCH_PREDECODE_EN
                if (e.ins[31:26] == 6'b000010) nxt = {nxt[31:28], e.ins[25:0], 2'b00};
`endif
                m_pc = nxt;
            end
            m_boot = 1;
        end
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst            = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            if (mem[i][31:26] == 6'b000010) mem[i][31:26] = 6'b000011;
        end
        mem[6] = 32'h0800_0006;
        q.delete();
        m_pc   = RST_PC;
        m_boot = 0;
        m_mis  = 0;
        m_cnt  = 0;
        repeat (2) @(posedge clk);

        // Reset state, then streaming through the address wrap and program start.
        step(1, 1, 0, 32'h0);
        step(1, 1, 0, 32'h0);
        repeat (14) step(0, 1, 0, 32'h0);

        // Stall with decode not ready, then drain in order.
        step(1, 0, 0, 32'h0);
        repeat (6) step(0, 0, 0, 32'h0);
        repeat (5) step(0, 1, 0, 32'h0);

        // Full buffer flushed by an aligned redirect with a same-cycle pop.
        repeat (3) step(0, 0, 0, 32'h0);
        step(0, 1, 1, 32'h0000_0004);
        repeat (4) step(0, 1, 0, 32'h0);

        // Misaligned redirect sets the sticky flag.
        step(0, 1, 1, 32'h0000_0016);
        repeat (5) step(0, 1, 0, 32'h0);
        step(0, 0, 1, 32'h0000_0010);
        repeat (3) step(0, 1, 0, 32'h0);

        // Long stream reaching the jump word and saturating the counter, then reset mid-stream.
        step(1, 1, 0, 32'h0);
        repeat (40) step(0, 1, 0, 32'h0);
        step(1, 1, 0, 32'h0);
        repeat (4) step(0, 1, 0, 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] rpc;
            bit          r;
            bit          rv;
            r   = ($urandom_range(0, 299) == 0);
            rv  = ($urandom_range(0, 9) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                              : 32'($urandom_range(0, 255));
            step(r, ($urandom_range(0, 9) < 7), rv, rpc);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
